// File: rtl/sar_pkg.sv
// sar_pkg: shared state encoding and width helpers for the SAR sequencer
package sar_pkg;
  typedef enum logic [1:0] {IDLE, SAMPLE, CONV} state_t;
  localparam int CNT_W = 16;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sar_core.sv
// sar_core: one MSB-first binary search; go starts, done marks the LSB-compare cycle with code final
//   in  clk, rst, go, cmp   out DACF (trial code), code (resolved code), done
module sar_core import sar_pkg::*; #(
  parameter int ADC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 cmp,
  output logic [ADC_WIDTH-1:0] DACF,
  output logic [ADC_WIDTH-1:0] code,
  output logic                 done
);
  localparam int BW = clog2_min1(ADC_WIDTH);
  localparam logic [ADC_WIDTH-1:0] ONE = ADC_WIDTH'(1);
  logic [ADC_WIDTH-1:0] dac_q, dac_d;
  logic [BW-1:0] bit_q, bit_d;
  logic act_q, act_d;
  always_comb begin
    code = cmp ? dac_q : dac_q & ~(ONE << bit_q);
    done = act_q && bit_q == '0;
    act_d = go || (act_q && !done);
    bit_d = go ? BW'(ADC_WIDTH - 1) : (act_q && !done) ? bit_q - 1'b1 : bit_q;
    dac_d = go ? ONE << (ADC_WIDTH - 1) : (act_q && !done) ? code | (ONE << (bit_q - 1'b1)) : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dac_q <= '0;
      bit_q <= '0;
      act_q <= 1'b0;
    end else begin
      dac_q <= dac_d;
      bit_q <= bit_d;
      act_q <= act_d;
    end
  assign DACF = dac_q;
endmodule

// File: rtl/sar_adc_seq.sv
// sar_adc_seq: multi-channel SAR ADC sequencer with settle window, averaging and scan/continuous modes
//   in  clk, rst (async), start, mode_scan, mode_cont, stop, ch_in, cmp
//   out DACF, ch_sel, smp, busy, den, Dout, dch, eoc
module sar_adc_seq import sar_pkg::*; #(
  parameter int ADC_WIDTH  = 8,
  parameter int NUM_CH     = 4,
  parameter int SETTLE_CYC = 2,
  parameter int AVG_LOG2   = 0,
  localparam int CH_W = clog2_min1(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode_scan,
  input  logic                 mode_cont,
  input  logic                 stop,
  input  logic [CH_W-1:0]      ch_in,
  input  logic                 cmp,
  output logic [ADC_WIDTH-1:0] DACF,
  output logic [CH_W-1:0]      ch_sel,
  output logic                 smp,
  output logic                 busy,
  output logic                 den,
  output logic [ADC_WIDTH-1:0] Dout,
  output logic [CH_W-1:0]      dch,
  output logic                 eoc
);
  localparam int AW = ADC_WIDTH + AVG_LOG2;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [AVG_LOG2:0] K_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AVG_LOG2:0] nsmp_q, nsmp_d;
  logic [AW-1:0] acc_q, acc_d, sum;
  logic [CH_W-1:0] ch_q, ch_d, chin_q, chin_d, dch_q, dch_d, chc;
  logic [ADC_WIDTH-1:0] dout_q, dout_d, code;
  logic scan_q, scan_d, cont_q, cont_d, stop_q, stop_d, busy_q, busy_d;
  logic den_q, den_d, eoc_q, eoc_d, go, done, last;
  sar_core #(.ADC_WIDTH(ADC_WIDTH)) u_core (
    .clk(clk), .rst(rst), .go(go), .cmp(cmp), .DACF(DACF), .code(code), .done(done)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    nsmp_d = nsmp_q;
    acc_d = acc_q;
    ch_d = ch_q;
    chin_d = chin_q;
    scan_d = scan_q;
    cont_d = cont_q;
    dout_d = dout_q;
    dch_d = dch_q;
    den_d = 1'b0;
    eoc_d = 1'b0;
    go = 1'b0;
    chc = ch_in > CH_LAST ? CH_LAST : ch_in;
    sum = acc_q + AW'(code);
    last = !scan_q || ch_q == CH_LAST;
    if (state_q == IDLE) begin
      if (start && !busy_q) begin
        state_d = SAMPLE;
        scan_d = mode_scan;
        cont_d = mode_cont;
        chin_d = chc;
        ch_d = mode_scan ? '0 : chc;
        cnt_d = '0;
        nsmp_d = '0;
        acc_d = '0;
      end
    end else if (state_q == SAMPLE) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == SET_LAST) begin
        go = 1'b1;
        cnt_d = '0;
        state_d = CONV;
      end
    end else if (done) begin
      state_d = SAMPLE;
      nsmp_d = nsmp_q + 1'b1;
      acc_d = sum;
      if (nsmp_q == K_LAST) begin
        nsmp_d = '0;
        acc_d = '0;
        den_d = 1'b1;
        dout_d = sum[AW-1:AVG_LOG2];
        dch_d = ch_q;
        eoc_d = last;
        ch_d = last ? (scan_q ? '0 : chin_q) : ch_q + 1'b1;
        // a stop seen in this very cycle still ends the sequence
        if (last && !(cont_q && !stop_q && !stop)) begin
          state_d = IDLE;
          ch_d = ch_q;
        end
      end
    end
    stop_d = state_d != IDLE && (stop_q || (stop && busy_q));
    // busy spans the eoc cycle so a start there is still ignored
    busy_d = state_d != IDLE || eoc_d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      nsmp_q <= '0;
      acc_q <= '0;
      ch_q <= '0;
      chin_q <= '0;
      scan_q <= 1'b0;
      cont_q <= 1'b0;
      stop_q <= 1'b0;
      busy_q <= 1'b0;
      den_q <= 1'b0;
      eoc_q <= 1'b0;
      dout_q <= '0;
      dch_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      nsmp_q <= nsmp_d;
      acc_q <= acc_d;
      ch_q <= ch_d;
      chin_q <= chin_d;
      scan_q <= scan_d;
      cont_q <= cont_d;
      stop_q <= stop_d;
      busy_q <= busy_d;
      den_q <= den_d;
      eoc_q <= eoc_d;
      dout_q <= dout_d;
      dch_q <= dch_d;
    end
  assign ch_sel = ch_q;
  assign smp = state_q == SAMPLE;
  assign busy = busy_q;
  assign den = den_q;
  assign Dout = dout_q;
  assign dch = dch_q;
  assign eoc = eoc_q;
endmodule

// File: tb/tb_sar_adc_seq.sv
// tb_sar_adc_seq: directed scenarios checked every cycle against a timeline model of the sequencer
module tb_sar_adc_seq;
  localparam int W = 8, S = 2, MAXC = 1200;
  logic clk = 0, rst = 1, start0 = 0, start1 = 0, mode_scan = 0, mode_cont = 0, stop = 0;
  logic [1:0] ch_in = 0;
  logic cmp0, cmp1, smp0, smp1, busy0, busy1, den0, den1, eoc0, eoc1;
  logic [7:0] dacf0, dacf1, dout0, dout1;
  logic [1:0] chs0, chs1, dch0, dch1;
  logic [7:0] vin0 [4];
  int k1 = 0, cyc = 0, pass = 0, total = 0, e0 = 0;
  int exp_busy [2][MAXC], exp_smp [2][MAXC], exp_den [2][MAXC], exp_eoc [2][MAXC];
  int exp_dout [2][MAXC], exp_dch [2][MAXC], exp_ch [2][MAXC], exp_dac [2][MAXC];

  sar_adc_seq #(.ADC_WIDTH(8), .NUM_CH(4), .SETTLE_CYC(2), .AVG_LOG2(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .mode_scan(mode_scan), .mode_cont(mode_cont),
    .stop(stop), .ch_in(ch_in), .cmp(cmp0), .DACF(dacf0), .ch_sel(chs0), .smp(smp0),
    .busy(busy0), .den(den0), .Dout(dout0), .dch(dch0), .eoc(eoc0));
  sar_adc_seq #(.ADC_WIDTH(8), .NUM_CH(3), .SETTLE_CYC(2), .AVG_LOG2(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode_scan(mode_scan), .mode_cont(mode_cont),
    .stop(stop), .ch_in(ch_in), .cmp(cmp1), .DACF(dacf1), .ch_sel(chs1), .smp(smp1),
    .busy(busy1), .den(den1), .Dout(dout1), .dch(dch1), .eoc(eoc1));

  assign cmp0 = vin0[chs0] >= dacf0;
  assign cmp1 = (k1[0] ? 8'h13 : 8'h10) >= dacf1;
  always @(posedge smp1) k1 <= k1 + 1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s cyc=%0d: got %0d expected %0d", nm, cyc, act, exp);
  endtask

  function automatic int vin_at(input int d, input int ch, input int j);
    return d == 0 ? int'(vin0[ch]) : (j % 2 == 0 ? 'h13 : 'h10);
  endfunction

  // fill the expected timeline: each result takes K*(S+W) cycles, back to back
  task automatic plan(input int d, input int st, input bit scan, input int nseq, input int chin);
    int nch = d ? 3 : 4, k = d ? 4 : 1, t, nres, idx = 0, first, ch, b, v, o;
    t = k * (S + W);
    nres = scan ? nch : 1;
    first = chin > nch - 1 ? nch - 1 : chin;
    for (int s = 0; s < nseq; s++)
      for (int r = 0; r < nres; r++) begin
        ch = scan ? r : first;
        b = st + idx * t;
        for (int c = b; c < b + t; c++) begin
          o = (c - b) % (S + W);
          exp_busy[d][c] = 1;
          exp_smp[d][c] = o < S;
          exp_ch[d][c] = ch;
          exp_dac[d][c] = o < S ? 0 : o == S ? 128 : -1;
        end
        v = 0;
        for (int j = 0; j < k; j++) v += vin_at(d, ch, j);
        v = v / k;
        exp_den[d][b + t] = 1;
        exp_eoc[d][b + t] = r == nres - 1;
        for (int c = b + t; c < MAXC; c++) begin
          exp_dout[d][c] = v;
          exp_dch[d][c] = ch;
        end
        idx++;
      end
    exp_busy[d][st + idx * t] = 1;
  endtask

  task automatic abort(input int from);
    for (int d = 0; d < 2; d++)
      for (int c = from; c < MAXC; c++) begin
        exp_busy[d][c] = 0; exp_smp[d][c] = 0; exp_den[d][c] = 0; exp_eoc[d][c] = 0;
        exp_dout[d][c] = 0; exp_dch[d][c] = 0; exp_ch[d][c] = -1; exp_dac[d][c] = 0;
      end
  endtask

  task automatic cmp_cycle(input int d, input int c, input logic bsy, input logic sm, input logic dn,
                           input logic ec, input logic [7:0] dout, input logic [7:0] dac,
                           input logic [1:0] dc, input logic [1:0] cs);
    chk($sformatf("d%0d busy", d), int'(bsy), exp_busy[d][c]);
    chk($sformatf("d%0d smp", d), int'(sm), exp_smp[d][c]);
    chk($sformatf("d%0d den", d), int'(dn), exp_den[d][c]);
    chk($sformatf("d%0d eoc", d), int'(ec), exp_eoc[d][c]);
    chk($sformatf("d%0d Dout", d), int'(dout), exp_dout[d][c]);
    chk($sformatf("d%0d dch", d), int'(dc), exp_dch[d][c]);
    if (exp_ch[d][c] >= 0) chk($sformatf("d%0d ch_sel", d), int'(cs), exp_ch[d][c]);
    if (exp_dac[d][c] >= 0) chk($sformatf("d%0d DACF", d), int'(dac), exp_dac[d][c]);
  endtask

  always @(negedge clk)
    if (cyc < MAXC) begin
      cmp_cycle(0, cyc, busy0, smp0, den0, eoc0, dout0, dacf0, dch0, chs0);
      cmp_cycle(1, cyc, busy1, smp1, den1, eoc1, dout1, dacf1, dch1, chs1);
    end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic launch(input int d, input bit scan, input bit cont, input int nseq,
                        input int chin, output int st);
    @(negedge clk);
    mode_scan = scan;
    mode_cont = cont;
    ch_in = 2'(chin);
    st = cyc + 1;
    plan(d, st, scan, nseq, chin);
    if (d == 1) start1 = 1; else start0 = 1;
    @(negedge clk);
    start0 = 0;
    start1 = 0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < MAXC; c++) exp_ch[d][c] = -1;
    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy0), 0);
    chk("reset DACF", int'(dacf0), 0);
    chk("reset ch_sel", int'(chs0), 0);
    chk("reset Dout", int'(dout1), 0);
    rst = 0;
    repeat (2) @(negedge clk);

    vin0[0] = 8'h33; vin0[1] = 8'h5A; vin0[2] = 8'hA5; vin0[3] = 8'hC3;
    launch(0, 0, 0, 1, 2, e0);
    wait_cyc(e0 + 1); chk("s1 smp 2nd", int'(smp0), 1);
    wait_cyc(e0 + 2); chk("s1 smp off", int'(smp0), 0); chk("s1 msb trial", int'(dacf0), 8'h80);
    wait_cyc(e0 + 10);
    chk("s1 Dout", int'(dout0), 8'hA5); chk("s1 dch", int'(dch0), 2); chk("s1 eoc", int'(eoc0), 1);
    wait_cyc(e0 + 11); chk("s1 busy low", int'(busy0), 0);
    wait_cyc(e0 + 14);

    vin0[0] = 8'h00; vin0[1] = 8'hFF; vin0[2] = 8'h80; vin0[3] = 8'h7F;
    launch(0, 1, 0, 1, 0, e0);
    wait_cyc(e0 + 20); chk("s2 Dout ch1", int'(dout0), 8'hFF); chk("s2 eoc ch1", int'(eoc0), 0);
    wait_cyc(e0 + 40); chk("s2 Dout ch3", int'(dout0), 8'h7F); chk("s2 eoc ch3", int'(eoc0), 1);
    wait_cyc(e0 + 45);

    launch(1, 0, 0, 1, 3, e0);
    wait_cyc(e0 + 40);
    chk("s3 avg Dout", int'(dout1), 8'h11); chk("s3 clamp dch", int'(dch1), 2); chk("s3 den", int'(den1), 1);
    wait_cyc(e0 + 45);

    launch(0, 1, 1, 2, 0, e0);
    wait_cyc(e0 + 40); chk("s4 seq1 eoc", int'(eoc0), 1); chk("s4 busy kept", int'(busy0), 1);
    wait_cyc(e0 + 41); chk("s4 no gap smp", int'(smp0), 1);
    wait_cyc(e0 + 55); stop = 1;
    @(negedge clk); stop = 0;
    wait_cyc(e0 + 80); chk("s4 seq2 eoc", int'(eoc0), 1); chk("s4 seq2 Dout", int'(dout0), 8'h7F);
    wait_cyc(e0 + 81); chk("s4 idle", int'(busy0), 0);
    wait_cyc(e0 + 100);

    vin0[0] = 8'h33; vin0[1] = 8'h5A; vin0[2] = 8'hA5; vin0[3] = 8'hC3;
    launch(0, 0, 0, 1, 2, e0);
    wait_cyc(e0 + 3);
    start0 = 1; ch_in = 0; mode_scan = 1; mode_cont = 1;
    @(negedge clk); start0 = 0;
    wait_cyc(e0 + 10); chk("s5 Dout", int'(dout0), 8'hA5); chk("s5 dch", int'(dch0), 2);
    wait_cyc(e0 + 15);

    launch(0, 0, 0, 1, 2, e0);
    wait_cyc(e0 + 5);
    @(posedge clk); #2;
    abort(cyc);
    rst = 1;
    #1;
    chk("s6 async busy", int'(busy0), 0); chk("s6 async DACF", int'(dacf0), 0);
    chk("s6 async Dout", int'(dout0), 0); chk("s6 async smp", int'(smp0), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    wait_cyc(cyc + 3);
    launch(0, 0, 0, 1, 2, e0);
    wait_cyc(e0 + 10); chk("s6 Dout after", int'(dout0), 8'hA5);
    wait_cyc(e0 + 15);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/sar_adc_seq.md
Name: sar_adc_seq

Overview:
Parametrised successor to the single-channel SAR_ADC controller. It drives an external comparator and DAC through a binary search, with these additions:
- NUM_CH-channel analog-mux sequencing.
- Per-channel sample/settle window.
- Power-of-two oversampling/averaging.
- Single-shot or continuous scan modes.
It sits between the FPGA-side comparator input and the DAC/mux pins, and emits tagged results to downstream logic.

Parameters:
ADC_WIDTH, 8, conversion resolution in bits (DACF/Dout width).
NUM_CH, 4, number of analog channels, at least 1.
SETTLE_CYC, 2, cycles smp is held high before each conversion, at least 1.
AVG_LOG2, 0, log2 of samples averaged per result; 0 disables averaging.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; accepted only when busy=0
mode_scan  in  1  1 = sweep channels 0..NUM_CH-1; 0 = convert ch_in only; sampled with start
mode_cont  in  1  1 = repeat sequence until stop; sampled with start
stop  in  1  level or pulse; ends continuous mode after the current sequence
ch_in  in  CH_W  channel for single mode; CH_W = max(1, clog2(NUM_CH))
cmp  in  1  comparator output; 1 = Vin >= DAC
DACF  out  ADC_WIDTH  trial code to DAC
ch_sel  out  CH_W  analog mux select
smp  out  1  sample/hold enable
busy  out  1  high from start acceptance until return to IDLE
den  out  1  one-cycle result strobe
Dout  out  ADC_WIDTH  result, valid while den=1 and held until the next den
dch  out  CH_W  channel tag of Dout
eoc  out  1  one-cycle pulse coincident with den of the last channel in a sequence

Behaviour:
Reset values:
- All outputs are 0.
- FSM is in IDLE, accumulators cleared, cont latch cleared.
- rst asserted mid-conversion aborts immediately with no den/eoc.

States: IDLE, SAMPLE, CONV.

IDLE:
- On start=1 at edge E0: latch mode_scan and mode_cont.
- ch_sel <= ch_in (single mode) or 0 (scan mode).
- busy <= 1, go to SAMPLE.

SAMPLE:
- smp=1 and DACF=0 for exactly SETTLE_CYC cycles.
- Then enter CONV with DACF = MSB-only (1 << ADC_WIDTH-1).

CONV:
- Takes ADC_WIDTH cycles. Each cycle holds one trial code; cmp is sampled at the cycle's closing edge.
- cmp=1 keeps the trial bit, cmp=0 clears it; the next lower bit is then set as the new trial.
- The final code is formed at the edge that samples the LSB compare.

Averaging:
- K = 2^AVG_LOG2 samples per result, each a full SAMPLE+CONV.
- Accumulator width is ADC_WIDTH+AVG_LOG2 and never overflows.
- Dout = acc >> AVG_LOG2, truncated with no rounding.

Result timing:
- den, Dout and dch are registered at the edge completing the K-th conversion.
- First den is high in the cycle beginning at E0 + K*(SETTLE_CYC+ADC_WIDTH).

Sequencing:
- Scan mode advances ch_sel by 1 after each result and immediately enters SAMPLE. There are no idle cycles between channels.
- After the last channel (or the single channel), eoc=1 together with den.
- If cont is latched and no stop has been seen, restart at channel 0 (scan) or ch_in (single) in SAMPLE with zero gap.
- Otherwise return to IDLE; busy=0 in the cycle after eoc.

stop:
- stop=1 in any cycle while busy sets a stop flag.
- The current sequence finishes normally (eoc issued), then the FSM enters IDLE.
- The stop flag is cleared on entry to IDLE.

Other boundary rules:
- start while busy=1 is ignored, as are mode and ch_in changes.
- If ch_in >= NUM_CH, it is clamped to NUM_CH-1.
- If NUM_CH=1, scan and single modes are identical.

Decomposition:
Package sar_pkg holds:
- state enum typedef (IDLE/SAMPLE/CONV).
- clog2-based CH_W helper function.
- bit-counter width constant.

Sub-module sar_core performs one binary search:
- Ports: clk, rst, go, cmp, DACF, code, done.
- Parameter: ADC_WIDTH.
- The sequencer instantiates it once and owns the sample, average and channel logic.

Test Plan:
1. Defaults, single mode, ch_in=2; comparator model cmp=(vin[ch_sel]>=DACF) with vin[2]=8'hA5; start pulse -> smp high 2 cycles; den at E0+10 with Dout=8'hA5, dch=2; eoc coincident with den; busy low next cycle.
2. Scan mode, vin={8'h00,8'hFF,8'h80,8'h7F} -> four dens spaced 10 cycles apart; Dout 00, FF, 80, 7F; dch 0..3; eoc only on the 4th den.
3. AVG_LOG2=2, vin toggling per sample 8'h10/8'h13 -> acc=0x46; one den at E0+40 with Dout=8'h11.
4. Continuous scan; stop pulsed mid-way through channel 1 of the 2nd sequence -> 2nd sequence completes all 4 channels with eoc, then IDLE; no 3rd sequence; the first and second sequences run with no gap.
5. start pulsed again while busy, plus ch_in changed -> ignored; results and timing identical to scenario 1.
6. rst asserted during CONV bit 3 -> all outputs 0 asynchronously; no den/eoc; after release, a new start converts correctly.
